// File: rtl/mux_scan_nx1_pkg.sv
// Shared types and helpers for the N:1 manual/auto-scan multiplexer.
package mux_scan_nx1_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Index width for n channels; never narrower than one bit.
  function automatic int unsigned clog2w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_scan_nx1_next_ch_find.sv
// Combinational search for the next unmasked channel above ch, wrapping modulo N.
module next_ch_find
  import mux_scan_nx1_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [clog2w(N)-1:0] ch,
  input  logic [N-1:0]         mask,
  output logic [clog2w(N)-1:0] next_ch,
  output logic                 wrap,
  output logic                 none
);

  localparam int unsigned CW = clog2w(N);

  logic [CW-1:0] idx;
  logic          found;

  // First open slot in ch+1 .. ch+N; landing at or below ch means we wrapped.
  always_comb begin
    next_ch = ch;
    wrap    = 1'b0;
    none    = &mask;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = CW'((32'(ch) + i) % N);
      if (!found && !mask[idx]) begin
        found   = 1'b1;
        next_ch = idx;
        wrap    = (idx <= ch);
      end
    end
  end

endmodule

// File: rtl/mux_scan_nx1.sv
// N:1 registered multiplexer with manual select and masked auto-scan with dwell.
module mux_scan_nx1
  import mux_scan_nx1_pkg::*;
#(
  parameter int unsigned W  = 1,
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 MODE,
  input  logic                 HOLD,
  input  logic [clog2w(N)-1:0] SEL,
  input  logic [DW-1:0]        DWELL,
  input  logic [N-1:0]         MASK,
  input  logic [N*W-1:0]       DIN,
  output logic [W-1:0]         DOUT,
  output logic [clog2w(N)-1:0] CH,
  output logic                 VALID,
  output logic                 WRAP
);

  localparam int unsigned CW = clog2w(N);

  state_e        state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;

  logic [CW-1:0] next_ch_c, first_ch_c;
  logic          next_wrap_c, none_c, sel_ok_c;
  logic          go_manual_c, go_scan_c, load_c;
  logic [W-1:0]  ch_data [N];

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign ch_data[k] = DIN[k*W +: W];
  end

  next_ch_find #(.N(N)) u_next_ch_find (
    .ch      (ch_q),
    .mask    (MASK),
    .next_ch (next_ch_c),
    .wrap    (next_wrap_c),
    .none    (none_c)
  );

  // Lowest unmasked channel, used as the scan starting point.
  always_comb begin
    first_ch_c = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (!MASK[i]) first_ch_c = CW'(i);
    end
  end

  assign sel_ok_c = (32'(SEL) < N);

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    valid_d     = valid_q;
    wrap_d      = 1'b0;
    go_manual_c = 1'b0;
    go_scan_c   = 1'b0;
    load_c      = 1'b0;

    if (!HOLD) begin
      case (state_q)
        IDLE: begin
          valid_d = 1'b0;
          if (MODE == MODE_MANUAL) go_manual_c = 1'b1;
          else if (!none_c)        go_scan_c   = 1'b1;
        end
        MANUAL: begin
          if (MODE == MODE_MANUAL) go_manual_c = 1'b1;
          else if (!none_c)        go_scan_c   = 1'b1;
          else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
        SCAN: begin
          if (MODE == MODE_MANUAL) begin
            go_manual_c = 1'b1;
          end else if (none_c) begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
          end else if (MASK[ch_q] || (cnt_q >= DWELL)) begin
            // Dwell expired, lowered below the count, or current channel masked away.
            ch_d   = next_ch_c;
            wrap_d = next_wrap_c;
            cnt_d  = '0;
            load_c = 1'b1;
          end else begin
            cnt_d  = cnt_q + DW'(1);
            load_c = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase

      if (go_manual_c) begin
        state_d = MANUAL;
        cnt_d   = '0;
        if (sel_ok_c) begin
          ch_d    = SEL;
          valid_d = 1'b1;
          load_c  = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end

      if (go_scan_c) begin
        state_d = SCAN;
        ch_d    = first_ch_c;
        cnt_d   = '0;
        valid_d = 1'b1;
        load_c  = 1'b1;
      end

      if (load_c) dout_d = ch_data[ch_d];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign DOUT  = dout_q;
  assign CH    = ch_q;
  assign VALID = valid_q;
  assign WRAP  = wrap_q;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Self-checking bench for mux_scan_nx1: vector table, directed corner sequences, random vs model.
module tb_mux_scan_nx1;

  logic        CLK, RST_N, MODE, HOLD;
  logic [1:0]  SEL;
  logic [7:0]  DWELL;
  logic [3:0]  MASK;
  logic [31:0] DIN;
  logic [7:0]  DOUT;
  logic [1:0]  CH;
  logic        VALID, WRAP;

  logic [2:0]  sel5;
  logic [39:0] din5;
  logic [7:0]  dout5;
  logic [2:0]  ch5;
  logic        valid5, wrap5;

  int n_checks, n_fail;

  mux_scan_nx1 #(.W(8), .N(4), .DW(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .MODE(MODE), .HOLD(HOLD), .SEL(SEL), .DWELL(DWELL),
    .MASK(MASK), .DIN(DIN), .DOUT(DOUT), .CH(CH), .VALID(VALID), .WRAP(WRAP)
  );

  mux_scan_nx1 #(.W(8), .N(5), .DW(8)) dut5 (
    .CLK(CLK), .RST_N(RST_N), .MODE(1'b0), .HOLD(1'b0), .SEL(sel5), .DWELL(8'd0),
    .MASK(5'd0), .DIN(din5), .DOUT(dout5), .CH(ch5), .VALID(valid5), .WRAP(wrap5)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode decides the target behaviour, scan walks the open channels.
  int         m_state;  // 0 idle, 1 manual, 2 scan
  int         m_ch, m_spent;
  logic [7:0] m_dout;
  logic       m_valid, m_wrap;

  function automatic logic [7:0] chan(input int k);
    return DIN[k*8 +: 8];
  endfunction

  function automatic int lowest_open(input logic [3:0] m);
    for (int k = 0; k < 4; k++) if (!m[k]) return k;
    return 0;
  endfunction

  function automatic int step_from(input int from, input logic [3:0] m);
    for (int s = 1; s <= 4; s++) if (!m[(from + s) % 4]) return (from + s) % 4;
    return from;
  endfunction

  task automatic model_reset();
    m_state = 0; m_ch = 0; m_spent = 0; m_dout = 8'h00; m_valid = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_step();
    int nx;
    m_wrap = 1'b0;
    if (HOLD) return;
    if (!MODE) begin
      m_state = 1; m_spent = 0; m_ch = int'(SEL); m_valid = 1'b1; m_dout = chan(m_ch);
    end else if (MASK == 4'hF) begin
      m_state = 0; m_spent = 0; m_valid = 1'b0;
    end else if (m_state != 2) begin
      m_state = 2; m_spent = 0; m_ch = lowest_open(MASK); m_valid = 1'b1; m_dout = chan(m_ch);
    end else if (MASK[m_ch] || m_spent >= int'(DWELL)) begin
      nx = step_from(m_ch, MASK);
      m_wrap = (nx <= m_ch);
      m_ch = nx; m_spent = 0; m_dout = chan(m_ch);
    end else begin
      m_spent++; m_dout = chan(m_ch);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic compare_model();
    check("rnd_dout", 32'(DOUT), 32'(m_dout));
    check("rnd_ch", 32'(CH), 32'(m_ch));
    check("rnd_valid", 32'(VALID), 32'(m_valid));
    check("rnd_wrap", 32'(WRAP), 32'(m_wrap));
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  typedef struct {
    logic       mode, hold;
    logic [1:0] sel;
    logic [7:0] dwell;
    logic [3:0] mask;
    logic [7:0] e_dout;
    logic [1:0] e_ch;
    logic       e_valid, e_wrap;
  } vec_t;

  function automatic vec_t mk(input logic md, input logic hd, input logic [1:0] s,
                              input logic [7:0] dw, input logic [3:0] mk_m,
                              input logic [7:0] ed, input logic [1:0] ec,
                              input logic ev, input logic ew);
    vec_t v;
    v.mode = md; v.hold = hd; v.sel = s; v.dwell = dw; v.mask = mk_m;
    v.e_dout = ed; v.e_ch = ec; v.e_valid = ev; v.e_wrap = ew;
    return v;
  endfunction

  vec_t vecs[16];
  int   exp27[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  logic [7:0] saved;

  initial begin
    n_checks = 0; n_fail = 0;
    MODE = 1'b0; HOLD = 1'b0; SEL = 2'd2; DWELL = 8'd0; MASK = 4'h0; DIN = 32'h44332211;
    sel5 = 3'd0; din5 = 40'h5544332211;
    RST_N = 1'b0;
    model_reset();

    //           mode hold sel dwell mask     dout   ch   v  w
    vecs[0]  = mk(0, 0, 2'd2, 8'd0, 4'b0000, 8'h33, 2'd2, 1, 0);
    vecs[1]  = mk(0, 0, 2'd0, 8'd0, 4'b0000, 8'h11, 2'd0, 1, 0);
    vecs[2]  = mk(0, 0, 2'd3, 8'd0, 4'b0000, 8'h44, 2'd3, 1, 0);
    vecs[3]  = mk(1, 0, 2'd3, 8'd0, 4'b1010, 8'h11, 2'd0, 1, 0);
    vecs[4]  = mk(1, 0, 2'd3, 8'd0, 4'b1010, 8'h33, 2'd2, 1, 0);
    vecs[5]  = mk(1, 0, 2'd3, 8'd0, 4'b1010, 8'h11, 2'd0, 1, 1);
    vecs[6]  = mk(1, 0, 2'd3, 8'd0, 4'b1010, 8'h33, 2'd2, 1, 0);
    vecs[7]  = mk(1, 0, 2'd3, 8'd0, 4'b1010, 8'h11, 2'd0, 1, 1);
    vecs[8]  = mk(1, 0, 2'd3, 8'd0, 4'b1111, 8'h11, 2'd0, 0, 0);
    vecs[9]  = mk(0, 0, 2'd1, 8'd0, 4'b1111, 8'h22, 2'd1, 1, 0);
    vecs[10] = mk(0, 1, 2'd3, 8'd0, 4'b1111, 8'h22, 2'd1, 1, 0);
    vecs[11] = mk(1, 1, 2'd3, 8'd0, 4'b0000, 8'h22, 2'd1, 1, 0);
    vecs[12] = mk(0, 0, 2'd3, 8'd0, 4'b0000, 8'h44, 2'd3, 1, 0);
    vecs[13] = mk(1, 0, 2'd3, 8'd5, 4'b0110, 8'h11, 2'd0, 1, 0);
    vecs[14] = mk(1, 0, 2'd3, 8'd5, 4'b0001, 8'h22, 2'd1, 1, 0);
    vecs[15] = mk(1, 0, 2'd3, 8'd5, 4'b0001, 8'h22, 2'd1, 1, 0);

    #12;
    check("rst_dout", 32'(DOUT), 32'h0);
    check("rst_ch", 32'(CH), 32'h0);
    check("rst_valid", 32'(VALID), 32'h0);
    check("rst_wrap", 32'(WRAP), 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(mux_scan_nx1_pkg::IDLE));
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 16; i++) begin
      MODE = vecs[i].mode; HOLD = vecs[i].hold; SEL = vecs[i].sel;
      DWELL = vecs[i].dwell; MASK = vecs[i].mask;
      tick();
      check($sformatf("vec%0d_dout", i), 32'(DOUT), 32'(vecs[i].e_dout));
      check($sformatf("vec%0d_ch", i), 32'(CH), 32'(vecs[i].e_ch));
      check($sformatf("vec%0d_valid", i), 32'(VALID), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_wrap", i), 32'(WRAP), 32'(vecs[i].e_wrap));
    end

    // Single open channel: stays selected, WRAP every DWELL+1 cycles.
    MASK = 4'b1011; DWELL = 8'd1; MODE = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      check("single_ch", 32'(CH), 32'd2);
      check("single_wrap", 32'(WRAP), 32'((t >= 3) && (t % 2 == 1)));
    end

    // N=5 instance: select indices at and beyond the last channel.
    sel5 = 3'd4; tick();
    check("n5_sel4_dout", 32'(dout5), 32'h55);
    check("n5_sel4_ch", 32'(ch5), 32'd4);
    check("n5_sel4_valid", 32'(valid5), 32'd1);
    sel5 = 3'd5; din5 = 40'hAA99887766; tick();
    check("n5_sel5_valid", 32'(valid5), 32'd0);
    check("n5_sel5_dout", 32'(dout5), 32'h55);
    check("n5_sel5_ch", 32'(ch5), 32'd4);
    sel5 = 3'd7; tick();
    check("n5_sel7_valid", 32'(valid5), 32'd0);
    sel5 = 3'd1; tick();
    check("n5_sel1_dout", 32'(dout5), 32'h77);
    check("n5_sel1_valid", 32'(valid5), 32'd1);
    check("n5_wrap", 32'(wrap5), 32'd0);

    // Full scan with dwell 2.
    MODE = 1'b1; MASK = 4'h0; DWELL = 8'd2; HOLD = 1'b0; DIN = 32'hD4C3B2A1;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      tick();
      check($sformatf("scan27_ch%0d", i), 32'(CH), 32'(exp27[i]));
      check($sformatf("scan27_wrap%0d", i), 32'(WRAP), 32'(i == 12));
      check($sformatf("scan27_dout%0d", i), 32'(DOUT), 32'(chan(exp27[i])));
    end

    // All channels masked while at CH=1, then unmasked again.
    repeat (3) tick();
    check("mask_all_pre_ch", 32'(CH), 32'd1);
    saved = DOUT;
    MASK = 4'hF; DIN = ~DIN;
    tick();
    check("mask_all_valid", 32'(VALID), 32'd0);
    check("mask_all_dout", 32'(DOUT), 32'(saved));
    check("mask_all_state", 32'(dut.state_q), 32'(mux_scan_nx1_pkg::IDLE));
    MASK = 4'h0;
    tick();
    check("unmask_ch", 32'(CH), 32'd0);
    check("unmask_valid", 32'(VALID), 32'd1);
    check("unmask_dout", 32'(DOUT), 32'(chan(0)));

    // HOLD mid-dwell: nothing moves, then the remaining dwell completes.
    DWELL = 8'd4; DIN = 32'h0F1E2D3C;
    do_reset();
    repeat (3) tick();
    saved = DOUT;
    HOLD = 1'b1;
    for (int i = 0; i < 5; i++) begin
      DIN = $urandom;
      tick();
      check("hold_ch", 32'(CH), 32'd0);
      check("hold_dout", 32'(DOUT), 32'(saved));
      check("hold_cnt", 32'(dut.cnt_q), 32'd2);
      check("hold_valid", 32'(VALID), 32'd1);
      check("hold_wrap", 32'(WRAP), 32'd0);
    end
    HOLD = 1'b0;
    tick(); check("rel1_ch", 32'(CH), 32'd0);
    tick(); check("rel2_ch", 32'(CH), 32'd0);
    tick(); check("rel3_ch", 32'(CH), 32'd1);
    check("rel3_dout", 32'(DOUT), 32'(chan(1)));

    // Asynchronous reset between edges mid-scan.
    #3 RST_N = 1'b0;
    #1;
    model_reset();
    check("arst_dout", 32'(DOUT), 32'h0);
    check("arst_ch", 32'(CH), 32'h0);
    check("arst_valid", 32'(VALID), 32'h0);
    check("arst_wrap", 32'(WRAP), 32'h0);
    @(posedge CLK); #1;
    check("arst_hold_ch", 32'(CH), 32'h0);
    MODE = 1'b1; MASK = 4'b0011;
    #2 RST_N = 1'b1;
    tick();
    check("arst_restart_ch", 32'(CH), 32'd2);
    check("arst_restart_valid", 32'(VALID), 32'd1);
    check("arst_restart_dout", 32'(DOUT), 32'(chan(2)));

    // Random stimulus against the model.
    MODE = 1'b1; MASK = 4'h0; DWELL = 8'd1; HOLD = 1'b0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 19) == 0) MODE = ~MODE;
      HOLD = ($urandom_range(0, 7) == 0);
      SEL = 2'($urandom);
      if ($urandom_range(0, 9) == 0) DWELL = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) MASK = 4'($urandom);
      DIN = $urandom;
      tick();
      compare_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
